program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Hardware counterpart of the bench-side `$readmemb` program load.
- Receives a byte stream over a valid/ready handshake, assembles DATA_W-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU in reset until the image is fully loaded.
- Sits between a byte source (UART receiver or test driver) and the ROM write port of the Computer.

Parameters:
- ADDR_W, 8, instruction memory address width
- DATA_W, 16, memory word width; must be a multiple of 8
- BASE_ADDR, 0, address of the first word written

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte
- reload  input  1  one-cycle pulse: restart the load from DONE or ERROR
- mem_we  output  1  memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  DATA_W  write data
- cpu_hold  output  1  high keeps the CPU in reset
- load_done  output  1  image loaded successfully
- load_error  output  1  malformed image

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst).
- Reset values: state HDR_HI, rx_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, word/byte counters=0.
- Byte handshake: a byte is accepted on a rising clk edge where rx_valid && rx_ready. rx_ready is combinational from state: 1 in HDR_HI, HDR_LO, DATA and CHK; 0 in DONE and ERROR.
- Frame format (all fields big-endian):
  - 16-bit word count N.
  - N words of DATA_W/8 bytes each.
  - Checksum byte (only when the optional feature is enabled).
- State machine:
  - HDR_HI: accept byte -> count[15:8] -> HDR_LO.
  - HDR_LO: accept byte -> count[7:0].
    - N == 0 -> DONE (CHK if feature enabled).
    - N > 2**ADDR_W - BASE_ADDR -> ERROR.
    - Otherwise -> DATA.
  - DATA: shift each accepted byte into the word register, MSB first.
    - On the last byte of a word, in the next cycle: mem_we=1, mem_wdata=assembled word, mem_addr=current address.
    - Address increments after the write.
    - After word N -> DONE (or CHK). No address wrap is possible because of the header bound.
  - CHK: see Optional Feature.
  - DONE: load_done=1, cpu_hold=0; all further bytes are ignored (rx_ready=0).
  - ERROR: load_error=1, cpu_hold=1; no further memory writes.
- Write latency: mem_we asserts exactly 1 cycle after the handshake of the final byte of a word and lasts 1 cycle. mem_addr/mem_wdata are stable while mem_we=1. Back-to-back bytes are accepted with no stall (rx_ready stays 1 during the write cycle).
- rx_valid low: the FSM holds state; gaps between bytes are unlimited.
- reload in DONE/ERROR: next cycle -> HDR_HI, address=BASE_ADDR, flags cleared, cpu_hold=1. reload is ignored in all other states.
- Reset mid-load: immediate return to reset values. Words already written are not undone. cpu_hold stays asserted.
- Counters: word counter is 16 bits; byte index is clog2(DATA_W/8) bits, minimum 1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After word N (or after the header when N=0), state CHK accepts one byte.
  - That byte must equal the XOR of all payload data bytes (header excluded).
  - Match -> DONE. Mismatch -> ERROR.
  - Data words are already written during DATA regardless of the checksum outcome; cpu_hold stays 1 on mismatch.
- Undefined: CHK state and XOR register are absent; the transition after the last word goes directly to DONE.

Decomposition:
- Shared package loader_pkg:
  - State encoding: HDR_HI, HDR_LO, DATA, CHK, DONE, ERROR.
  - HDR_BYTES=2.
  - BYTES_PER_WORD derivation.
- Sub-module byte_assembler: shifts bytes into a DATA_W register, outputs word_valid on the final byte. Instantiated once.

Test Plan:
- Bytes 00 02 12 34 AB CD (no checksum) -> writes 0x1234 @0, 0xABCD @1; load_done=1, cpu_hold=0 one cycle after the last write.
- Header 00 00 -> no mem_we; DONE reached the cycle after the second byte (CHK first if the macro is defined).
- Header 01 01 with ADDR_W=8, BASE_ADDR=0 -> ERROR, load_error=1, rx_ready=0, no writes.
- Random rx_valid gaps on a 3-word image -> same writes and addresses as the gap-free run; one mem_we per word.
- rst low after 1 of 3 words -> all outputs at reset values; re-sending the full image rewrites @0..2 correctly.
- LOADER_CHECKSUM_EN: 00 01 12 34 26 -> DONE; same image with checksum 27 -> ERROR. Then reload and resend the good image -> DONE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, header size
// and the byte/word geometry helpers.
package loader_pkg;

    localparam int HDR_BYTES = 2;

    localparam logic [2:0] ST_HDR_HI = 3'd0;
    localparam logic [2:0] ST_HDR_LO = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CHK    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Byte index is never narrower than one bit, even for 8- or 16-bit words.
    function automatic int byte_idx_w(input int data_w);
        int bpw;
        bpw = data_w / 8;
        return (bpw <= 2) ? 1 : $clog2(bpw);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Shifts accepted bytes MSB-first into a DATA_W word and flags the byte that
// completes it; word is only meaningful while word_valid is high.
module byte_assembler
    import loader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = byte_idx_w(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  idx;

    // The completed word includes the byte arriving this cycle, so the top
    // level can register it on the same edge that accepts the final byte.
    assign word       = DATA_W'({shift_reg, byte_in});
    assign word_valid = byte_valid && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            idx       <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            idx       <= '0;
        end else if (byte_valid) begin
            shift_reg <= word;
            idx       <= word_valid ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a big-endian word-count header, writes
// the payload words into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [63:0] MAX_WORDS = (64'd1 << ADDR_W) - 64'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_CHK;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

    logic [2:0]        state;
    logic [7:0]        count_hi;
    logic [15:0]       word_total;
    logic [15:0]       word_cnt;
    logic [15:0]       header_count;
    logic              accept;
    logic              reload_fire;
    logic              data_accept;
    logic [DATA_W-1:0] asm_word;
    logic              asm_word_valid;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    // NOTE: rx_ready is decoded from the registered state only; it never
    // depends on rx_valid, so the handshake cannot form a combinational loop.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK: rx_ready = 1'b1;
            default:                               rx_ready = 1'b0;
        endcase
    end

    assign accept       = rx_valid && rx_ready;
    assign data_accept  = accept && (state == ST_DATA);
    assign reload_fire  = reload && ((state == ST_DONE) || (state == ST_ERROR));
    assign header_count = {count_hi, rx_data};

    byte_assembler #(
        .DATA_W(DATA_W)
    ) u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload_fire),
        .byte_in    (rx_data),
        .byte_valid (data_accept),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // NOTE: all state here uses non-blocking assignments; later assignments in
    // the block deliberately override earlier ones (reload beats increment).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_HDR_HI;
            count_hi   <= '0;
            word_total <= '0;
            word_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end

            case (state)
                ST_HDR_HI: begin
                    if (accept) begin
                        count_hi <= rx_data;
                        state    <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        word_total <= header_count;
                        word_cnt   <= '0;
                        if (header_count == 16'd0) begin
                            state <= ST_AFTER_DATA;
                        end else if (64'(header_count) > MAX_WORDS) begin
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (data_accept) begin
                        chk_acc <= chk_acc ^ rx_data;
                    end
`endif
                    if (asm_word_valid) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= asm_word;
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt == word_total - 16'd1) begin
                            state <= ST_AFTER_DATA;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        state <= (rx_data == chk_acc) ? ST_DONE : ST_ERROR;
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (reload_fire) begin
                        state    <= ST_HDR_HI;
                        mem_addr <= BASE;
                        word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc  <= '0;
`endif
                    end
                end
                default: state <= ST_ERROR;
            endcase
        end
    end

    // Status flags trail the state by one cycle, so load_done rises the cycle
    // after the final memory write has been presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_done  <= (state == ST_DONE) && !reload_fire;
            load_error <= (state == ST_ERROR) && !reload_fire;
            cpu_hold   <= !((state == ST_DONE) && !reload_fire);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized images and byte gaps
// checked against a frame-level reference model; honours LOADER_CHECKSUM_EN.
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int MAX_N = 256;  // 2**ADDR_W - BASE_ADDR for the default build

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int errors = 0;
    int checks = 0;
    int we_total = 0;
    logic [15:0] img_words[$];

    program_loader #(
        .ADDR_W(8),
        .DATA_W(16),
        .BASE_ADDR(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && mem_we) we_total++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_ready", rx_ready, 1);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reload   = 1'b0;
        rst      = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Presents one byte; returns at 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        budget   = 0;
        while (!rx_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!rx_ready) begin
            check("ready_timeout", 0, 1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reload();
        rx_valid = 1'b0;
        reload   = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        check("reload_ready", rx_ready, 1);
        check("reload_done", load_done, 0);
        check("reload_error", load_error, 0);
        check("reload_hold", cpu_hold, 1);
        check("reload_addr", mem_addr, 0);
    endtask

    task automatic offer_ignored();
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("ignored_ready", rx_ready, 0);
        check("ignored_we", mem_we, 0);
        rx_valid = 1'b0;
    endtask

    // Sends header + img_words (+ checksum) and checks every write against the
    // frame model: word i lands at address i, one strobe per word.
    task automatic run_image(input int n, input int max_gap, input bit corrupt);
        logic [7:0]  chk;
        logic [15:0] nn;
        bit          ok;
        int          start;
        start = we_total;
        nn    = 16'(n);
        chk   = 8'h00;
        ok    = (n <= MAX_N) && !(CHK_EN && corrupt);
        send_byte(nn[15:8], $urandom_range(max_gap, 0));
        send_byte(nn[7:0], $urandom_range(max_gap, 0));
        if (n > MAX_N) begin
            rx_valid = 1'b0;
            check("hdr_err_ready", rx_ready, 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                send_byte(img_words[i][15:8], $urandom_range(max_gap, 0));
                check("we_mid_word", mem_we, 0);
                send_byte(img_words[i][7:0], $urandom_range(max_gap, 0));
                check("we_latency", mem_we, 1);
                check("wr_addr", mem_addr, i);
                check("wr_data", mem_wdata, img_words[i]);
                chk = chk ^ img_words[i][15:8] ^ img_words[i][7:0];
            end
            if (CHK_EN) send_byte(chk ^ {7'd0, corrupt}, $urandom_range(max_gap, 0));
            rx_valid = 1'b0;
            check("end_ready", rx_ready, 0);
            check("done_lag", load_done, 0);
        end
        @(posedge clk);
        #1;
        check("final_done", load_done, ok);
        check("final_error", load_error, !ok);
        check("final_hold", cpu_hold, !ok);
        check("write_count", we_total - start, (n > MAX_N) ? 0 : n);
    endtask

    task automatic random_words(input int n);
        img_words.delete();
        for (int i = 0; i < n; i++) img_words.push_back(16'($urandom));
    endtask

    initial begin
        do_reset();

        // Two-word directed image.
        img_words = '{16'h1234, 16'hABCD};
        run_image(2, 0, 1'b0);
        offer_ignored();
        pulse_reload();

        // Empty image.
        img_words.delete();
        run_image(0, 0, 1'b0);
        pulse_reload();

        // Header over the address-space bound.
        run_image(257, 0, 1'b0);
        offer_ignored();
        pulse_reload();

        // Three words without and with gaps.
        img_words = '{16'hCAFE, 16'h0001, 16'h8000};
        run_image(3, 0, 1'b0);
        pulse_reload();
        run_image(3, 4, 1'b0);
        pulse_reload();

        // Checksum mismatch then the good image.
        img_words = '{16'h1234};
        run_image(1, 0, 1'b1);
        pulse_reload();
        run_image(1, 0, 1'b0);
        pulse_reload();

        // Reset after the first of three words, then a full resend.
        img_words = '{16'h1111, 16'h2222, 16'h3333};
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        check("partial_we", mem_we, 1);
        rx_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b1;
        run_image(3, 1, 1'b0);
        pulse_reload();

        // Randomized images and gaps.
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(8, 1);
            random_words(n);
            run_image(n, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
            pulse_reload();
        end

        // Largest legal image fills the whole address space.
        random_words(MAX_N);
        run_image(MAX_N, 0, 1'b0);
        pulse_reload();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
